// File: rtl/tconv_pkg.sv
// ---------------------------------------------------------------------------
// tconv_pkg -- shared types and constants for the transposed-convolution
// tile scheduler.
//
// Contents:
//   state_t    : scheduler FSM state encoding
//   STREAM_LAT : ifmap BRAM read latency in cycles (read issue -> data load)
//   DRAIN_LEN  : cycles spent shifting results out of the array per tile
//   IF_LEN_W   : width of the per-tile ifmap sample count
//   TILES_W    : width of the tile count
// ---------------------------------------------------------------------------
package tconv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int STREAM_LAT = 1;
    localparam int DRAIN_LEN  = 16;
    localparam int IF_LEN_W   = 14;
    localparam int TILES_W    = 8;

endpackage

// File: rtl/tconv_addr_gen.sv
// ---------------------------------------------------------------------------
// tconv_addr_gen -- combinational lane-address replication and one-hot
// ifmap bank decode. Every lane of the array reads the same address, so the
// scalar addresses are replicated across NUM_BRAMS lanes; the ifmap read
// enable selects exactly one bank per issued sample.
//
// Ports:
//   w_addr       in  W_ADDR_W            scalar weight address
//   if_addr      in  I_ADDR_W            scalar ifmap address
//   bank         in  4                   ifmap bank index for this sample
//   bank_en      in  1                   a sample is issued this cycle
//   w_addr_flat  out NUM_BRAMS*W_ADDR_W  replicated weight address
//   if_addr_flat out NUM_BRAMS*I_ADDR_W  replicated ifmap address
//   bank_onehot  out NUM_BRAMS           one-hot ifmap read enable
// ---------------------------------------------------------------------------
module tconv_addr_gen
    import tconv_pkg::*;
#(
    parameter int NUM_BRAMS = 16,
    parameter int W_ADDR_W  = 11,
    parameter int I_ADDR_W  = 10
) (
    input  logic [W_ADDR_W-1:0]           w_addr,
    input  logic [I_ADDR_W-1:0]           if_addr,
    input  logic [3:0]                    bank,
    input  logic                          bank_en,
    output logic [NUM_BRAMS*W_ADDR_W-1:0] w_addr_flat,
    output logic [NUM_BRAMS*I_ADDR_W-1:0] if_addr_flat,
    output logic [NUM_BRAMS-1:0]          bank_onehot
);

    assign w_addr_flat  = {NUM_BRAMS{w_addr}};
    assign if_addr_flat = {NUM_BRAMS{if_addr}};

    always_comb begin
        bank_onehot = '0;
        for (int i = 0; i < NUM_BRAMS; i++) begin
            bank_onehot[i] = bank_en && (bank == i[3:0]);
        end
    end

endmodule

// File: rtl/tconv_tile_scheduler.sv
// ---------------------------------------------------------------------------
// tconv_tile_scheduler -- sequences weight load, ifmap streaming and result
// drain for a transposed-convolution array, one tile at a time.
//
// Per tile: LOAD_W (2 cycles) -> STREAM (if_len+1 cycles) -> DRAIN
// (DRAIN_LEN cycles), i.e. if_len+19 cycles. After the last tile a single
// DONE cycle pulses done. All outputs are registered: each edge computes the
// next state and drives the outputs belonging to that next state, so the
// outputs always line up with the state they describe.
//
// Handshake: start is a single-cycle request honoured only in IDLE (and only
// when abort is low); config is sampled on that same edge. abort in any
// non-IDLE state returns to IDLE on the next edge with every enable low and
// no done pulse.
//
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   start, abort              job request pulse, synchronous job kill
//   busy, done                job active, one-cycle completion pulse
//   cfg_w_base/if_base        weight / ifmap base addresses
//   cfg_if_len, cfg_num_tiles samples per tile, number of tiles
//   w_re, w_addr_rd_flat      weight BRAM reads (all lanes same address)
//   if_re, if_addr_rd_flat    ifmap BRAM reads (one-hot bank)
//   ifmap_sel                 bank whose read data is loaded this cycle
//   en_weight_load, en_ifmap_load, en_psum, clear_psum, en_output
//                             array compute enables
//   done_select               output row being drained
//   dbg_state                 current FSM state
//   perf_cycles               busy cycle count (only with TCONV_SCHED_PERF_EN)
//
// Build option: define TCONV_SCHED_PERF_EN to add the perf_cycles counter.
// ---------------------------------------------------------------------------
module tconv_tile_scheduler
    import tconv_pkg::*;
#(
    parameter int NUM_BRAMS = 16,
    parameter int W_ADDR_W  = 11,
    parameter int I_ADDR_W  = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    input  logic [W_ADDR_W-1:0]           cfg_w_base,
    input  logic [I_ADDR_W-1:0]           cfg_if_base,
    input  logic [IF_LEN_W-1:0]           cfg_if_len,
    input  logic [TILES_W-1:0]            cfg_num_tiles,
    output logic [NUM_BRAMS-1:0]          w_re,
    output logic [NUM_BRAMS*W_ADDR_W-1:0] w_addr_rd_flat,
    output logic [NUM_BRAMS-1:0]          if_re,
    output logic [NUM_BRAMS*I_ADDR_W-1:0] if_addr_rd_flat,
    output logic [3:0]                    ifmap_sel,
    output logic [NUM_BRAMS-1:0]          en_weight_load,
    output logic [NUM_BRAMS-1:0]          en_ifmap_load,
    output logic [NUM_BRAMS-1:0]          en_psum,
    output logic [NUM_BRAMS-1:0]          clear_psum,
    output logic [NUM_BRAMS-1:0]          en_output,
    output logic [4:0]                    done_select,
`ifdef TCONV_SCHED_PERF_EN
    output logic [31:0]                   perf_cycles,
`endif
    output logic [2:0]                    dbg_state
);

    localparam logic [IF_LEN_W-1:0] DRAIN_LAST = IF_LEN_W'(DRAIN_LEN - 1);
    localparam logic [IF_LEN_W-1:0] LAT        = IF_LEN_W'(STREAM_LAT);

    state_t               state, nxt_state;
    logic [IF_LEN_W-1:0]  cnt, nxt_cnt;
    logic [TILES_W-1:0]   t, nxt_t;
    logic [W_ADDR_W-1:0]  w_base_q;
    logic [I_ADDR_W-1:0]  if_base_q;
    logic [IF_LEN_W-1:0]  if_len_q;
    logic [TILES_W-1:0]   tiles_q;
    logic                 accept;

    // Next-cycle output terms
    logic                 w_re_n, wl_n, issue_n, load_n, drain_n;
    logic [W_ADDR_W-1:0]  w_base_eff, w_addr_n;
    logic [I_ADDR_W-1:0]  if_addr_n;
    logic [IF_LEN_W-1:0]  lag_cnt;
    logic [NUM_BRAMS*W_ADDR_W-1:0] w_flat_n;
    logic [NUM_BRAMS*I_ADDR_W-1:0] if_flat_n;
    logic [NUM_BRAMS-1:0]          if_re_n;

    assign dbg_state = state;

    // Next-state / counter logic
    always_comb begin
        accept    = (state == IDLE) && start && !abort;
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_t     = t;
        if (abort && state != IDLE) begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        nxt_t     = '0;
                        nxt_cnt   = '0;
                        nxt_state = (cfg_if_len == '0 || cfg_num_tiles == '0) ? DONE : LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (cnt == '0) begin
                        nxt_cnt = IF_LEN_W'(1);
                    end else begin
                        nxt_state = STREAM;
                        nxt_cnt   = '0;
                    end
                end
                STREAM: begin
                    if (cnt == if_len_q) begin
                        nxt_state = DRAIN;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = cnt + IF_LEN_W'(1);
                    end
                end
                DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        nxt_cnt   = '0;
                        nxt_t     = t + TILES_W'(1);
                        // Compare with one extra bit so t+1 cannot wrap at 255.
                        nxt_state = ({1'b0, t} + 9'd1 < {1'b0, tiles_q}) ? LOAD_W : DONE;
                    end else begin
                        nxt_cnt = cnt + IF_LEN_W'(1);
                    end
                end
                DONE: begin
                    nxt_state = IDLE;
                    nxt_cnt   = '0;
                end
                default: begin
                    nxt_state = IDLE;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    // Outputs for the cycle that follows the coming edge
    always_comb begin
        // The first LOAD_W of a job is entered straight from IDLE, before the
        // config registers hold the new base.
        w_base_eff = accept ? cfg_w_base : w_base_q;
        w_re_n     = (nxt_state == LOAD_W) && (nxt_cnt == '0);
        wl_n       = (nxt_state == LOAD_W) && (nxt_cnt != '0);
        issue_n    = (nxt_state == STREAM) && (nxt_cnt < if_len_q);
        load_n     = (nxt_state == STREAM) && (nxt_cnt >= LAT);
        drain_n    = (nxt_state == DRAIN);
        w_addr_n   = w_base_eff + W_ADDR_W'(nxt_t);
        if_addr_n  = if_base_q + I_ADDR_W'(nxt_cnt >> 4);
        lag_cnt    = nxt_cnt - LAT;
    end

    tconv_addr_gen #(
        .NUM_BRAMS (NUM_BRAMS),
        .W_ADDR_W  (W_ADDR_W),
        .I_ADDR_W  (I_ADDR_W)
    ) u_addr_gen (
        .w_addr       (w_addr_n),
        .if_addr      (if_addr_n),
        .bank         (nxt_cnt[3:0]),
        .bank_en      (issue_n),
        .w_addr_flat  (w_flat_n),
        .if_addr_flat (if_flat_n),
        .bank_onehot  (if_re_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            t               <= '0;
            w_base_q        <= '0;
            if_base_q       <= '0;
            if_len_q        <= '0;
            tiles_q         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            w_re            <= '0;
            w_addr_rd_flat  <= '0;
            if_re           <= '0;
            if_addr_rd_flat <= '0;
            ifmap_sel       <= '0;
            en_weight_load  <= '0;
            en_ifmap_load   <= '0;
            en_psum         <= '0;
            clear_psum      <= '0;
            en_output       <= '0;
            done_select     <= '0;
`ifdef TCONV_SCHED_PERF_EN
            perf_cycles     <= '0;
`endif
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            t     <= nxt_t;
            if (accept) begin
                w_base_q  <= cfg_w_base;
                if_base_q <= cfg_if_base;
                if_len_q  <= cfg_if_len;
                tiles_q   <= cfg_num_tiles;
            end
            busy           <= (nxt_state != IDLE);
            done           <= (nxt_state == DONE);
            w_re           <= {NUM_BRAMS{w_re_n}};
            en_weight_load <= {NUM_BRAMS{wl_n}};
            clear_psum     <= {NUM_BRAMS{wl_n}};
            if_re          <= if_re_n;
            en_ifmap_load  <= {NUM_BRAMS{load_n}};
            en_psum        <= {NUM_BRAMS{load_n}};
            en_output      <= {NUM_BRAMS{drain_n}};
            // Addresses and selects only move when used, otherwise they hold.
            if (w_re_n)  w_addr_rd_flat  <= w_flat_n;
            if (issue_n) if_addr_rd_flat <= if_flat_n;
            if (load_n)  ifmap_sel       <= lag_cnt[3:0];
            if (drain_n) done_select     <= nxt_cnt[4:0];
`ifdef TCONV_SCHED_PERF_EN
            if (accept) begin
                perf_cycles <= '0;
            end else if (state != IDLE) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_tconv_tile_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tconv_tile_scheduler -- table-driven bench for tconv_tile_scheduler.
// Each table row names a job, a cycle index (cycle 0 = the cycle start is
// driven high) and the hand-computed outputs expected in that cycle.
// Hand-written sequences cover start-while-busy, abort, asynchronous reset
// mid-drain and (when built with TCONV_SCHED_PERF_EN) the perf counter.
// ---------------------------------------------------------------------------
module tb_tconv_tile_scheduler;

    localparam int NB = 16;
    localparam int WA = 11;
    localparam int IA = 10;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             start, abort, busy, done;
    logic [WA-1:0]    cfg_w_base;
    logic [IA-1:0]    cfg_if_base;
    logic [13:0]      cfg_if_len;
    logic [7:0]       cfg_num_tiles;
    logic [NB-1:0]    w_re, if_re, en_weight_load, en_ifmap_load, en_psum, clear_psum, en_output;
    logic [NB*WA-1:0] w_addr_rd_flat;
    logic [NB*IA-1:0] if_addr_rd_flat;
    logic [3:0]       ifmap_sel;
    logic [4:0]       done_select;
    logic [2:0]       dbg_state;
`ifdef TCONV_SCHED_PERF_EN
    logic [31:0]      perf_cycles;
`endif

    tconv_tile_scheduler #(.NUM_BRAMS(NB), .W_ADDR_W(WA), .I_ADDR_W(IA)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .busy            (busy),
        .done            (done),
        .cfg_w_base      (cfg_w_base),
        .cfg_if_base     (cfg_if_base),
        .cfg_if_len      (cfg_if_len),
        .cfg_num_tiles   (cfg_num_tiles),
        .w_re            (w_re),
        .w_addr_rd_flat  (w_addr_rd_flat),
        .if_re           (if_re),
        .if_addr_rd_flat (if_addr_rd_flat),
        .ifmap_sel       (ifmap_sel),
        .en_weight_load  (en_weight_load),
        .en_ifmap_load   (en_ifmap_load),
        .en_psum         (en_psum),
        .clear_psum      (clear_psum),
        .en_output       (en_output),
        .done_select     (done_select),
`ifdef TCONV_SCHED_PERF_EN
        .perf_cycles     (perf_cycles),
`endif
        .dbg_state       (dbg_state)
    );

    // Scoreboard counters
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Jobs and vectors
    typedef struct {
        logic [WA-1:0] w_base;
        logic [IA-1:0] if_base;
        logic [13:0]   if_len;
        logic [7:0]    tiles;
        int            ncyc;
    } job_t;

    typedef struct {
        int            job;
        int            cyc;
        logic          busy;
        logic          done;
        logic [15:0]   w_re;
        logic [WA-1:0] w_addr;
        logic [15:0]   if_re;
        logic [IA-1:0] if_addr;
        logic [3:0]    sel;
        logic [15:0]   en_wl;
        logic [15:0]   en_if;
        logic [15:0]   en_ps;
        logic [15:0]   clr;
        logic [15:0]   en_out;
        logic [4:0]    dsel;
    } vec_t;

    typedef struct {
        logic             busy, done;
        logic [NB-1:0]    w_re, if_re, en_wl, en_if, en_ps, clr, en_out;
        logic [NB*WA-1:0] w_flat;
        logic [NB*IA-1:0] if_flat;
        logic [3:0]       sel;
        logic [4:0]       dsel;
    } snap_t;

    job_t  jobs[5];
    vec_t  vecs[$];
    snap_t snaps[0:79];

    function automatic vec_t mv(int j, int c, logic b, logic d, logic [15:0] wre, logic [WA-1:0] wa,
                                logic [15:0] ire, logic [IA-1:0] ia, logic [3:0] s, logic [15:0] ewl,
                                logic [15:0] eif, logic [15:0] eps, logic [15:0] cl, logic [15:0] eo,
                                logic [4:0] ds);
        vec_t v;
        v.job = j; v.cyc = c; v.busy = b; v.done = d; v.w_re = wre; v.w_addr = wa;
        v.if_re = ire; v.if_addr = ia; v.sel = s; v.en_wl = ewl; v.en_if = eif;
        v.en_ps = eps; v.clr = cl; v.en_out = eo; v.dsel = ds;
        return v;
    endfunction

    function automatic snap_t take();
        snap_t s;
        s.busy = busy; s.done = done; s.w_re = w_re; s.if_re = if_re;
        s.en_wl = en_weight_load; s.en_if = en_ifmap_load; s.en_ps = en_psum;
        s.clr = clear_psum; s.en_out = en_output; s.w_flat = w_addr_rd_flat;
        s.if_flat = if_addr_rd_flat; s.sel = ifmap_sel; s.dsel = done_select;
        return s;
    endfunction

    // Driver tasks
    task automatic do_reset();
        start = 1'b0; abort = 1'b0; rst_n = 1'b0;
        cfg_w_base = '0; cfg_if_base = '0; cfg_if_len = '0; cfg_num_tiles = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_cfg(input job_t j);
        cfg_w_base = j.w_base; cfg_if_base = j.if_base;
        cfg_if_len = j.if_len; cfg_num_tiles = j.tiles;
        start = 1'b1;
    endtask

    // Resets, then leaves the bench in cycle 0 with start high.
    task automatic begin_job(input job_t j);
        do_reset();
        @(negedge clk);
        drive_cfg(j);
    endtask

    task automatic tick();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_job(input int ji);
        do_reset();
        for (int k = 0; k <= jobs[ji].ncyc; k++) begin
            @(negedge clk);
            snaps[k] = take();
            if (k == 0) drive_cfg(jobs[ji]);
            else        start = 1'b0;
        end
    endtask

    task automatic check_vec(input vec_t v);
        snap_t s;
        string p;
        s = snaps[v.cyc];
        p = $sformatf("j%0d c%0d", v.job, v.cyc);
        chk({p, " busy"},   256'(s.busy),    256'(v.busy));
        chk({p, " done"},   256'(s.done),    256'(v.done));
        chk({p, " w_re"},   256'(s.w_re),    256'(v.w_re));
        chk({p, " w_addr"}, 256'(s.w_flat),  256'({NB{v.w_addr}}));
        chk({p, " if_re"},  256'(s.if_re),   256'(v.if_re));
        chk({p, " if_addr"},256'(s.if_flat), 256'({NB{v.if_addr}}));
        chk({p, " sel"},    256'(s.sel),     256'(v.sel));
        chk({p, " en_wl"},  256'(s.en_wl),   256'(v.en_wl));
        chk({p, " en_if"},  256'(s.en_if),   256'(v.en_if));
        chk({p, " en_ps"},  256'(s.en_ps),   256'(v.en_ps));
        chk({p, " clr"},    256'(s.clr),     256'(v.clr));
        chk({p, " en_out"}, 256'(s.en_out),  256'(v.en_out));
        chk({p, " dsel"},   256'(s.dsel),    256'(v.dsel));
    endtask

    localparam logic [15:0] F = 16'hFFFF;

    logic saw_done;

    initial begin
        start = 1'b0; abort = 1'b0;
        cfg_w_base = '0; cfg_if_base = '0; cfg_if_len = '0; cfg_num_tiles = '0;

        // w_base, if_base, if_len, tiles, cycles captured
        jobs[0] = '{11'h010, 10'h020, 14'd4,  8'd1, 26};
        jobs[1] = '{11'h000, 10'h3FF, 14'd20, 8'd1, 42};
        jobs[2] = '{11'h005, 10'h100, 14'd1,  8'd3, 63};
        jobs[3] = '{11'h033, 10'h044, 14'd0,  8'd2, 3};
        jobs[4] = '{11'h007, 10'h008, 14'd5,  8'd0, 3};

        //                job cyc busy done w_re w_addr   if_re    if_addr  sel ewl eif eps clr eout dsel
        vecs.push_back(mv(0,  0, 0, 0, 0, 11'h000, 16'h0000, 10'h000, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mv(0,  1, 1, 0, F, 11'h010, 16'h0000, 10'h000, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mv(0,  2, 1, 0, 0, 11'h010, 16'h0000, 10'h000, 0, F, 0, 0, F, 0, 0));
        vecs.push_back(mv(0,  3, 1, 0, 0, 11'h010, 16'h0001, 10'h020, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mv(0,  4, 1, 0, 0, 11'h010, 16'h0002, 10'h020, 0, 0, F, F, 0, 0, 0));
        vecs.push_back(mv(0,  5, 1, 0, 0, 11'h010, 16'h0004, 10'h020, 1, 0, F, F, 0, 0, 0));
        vecs.push_back(mv(0,  6, 1, 0, 0, 11'h010, 16'h0008, 10'h020, 2, 0, F, F, 0, 0, 0));
        vecs.push_back(mv(0,  7, 1, 0, 0, 11'h010, 16'h0000, 10'h020, 3, 0, F, F, 0, 0, 0));
        vecs.push_back(mv(0,  8, 1, 0, 0, 11'h010, 16'h0000, 10'h020, 3, 0, 0, 0, 0, F, 0));
        vecs.push_back(mv(0, 23, 1, 0, 0, 11'h010, 16'h0000, 10'h020, 3, 0, 0, 0, 0, F, 15));
        vecs.push_back(mv(0, 24, 1, 1, 0, 11'h010, 16'h0000, 10'h020, 3, 0, 0, 0, 0, 0, 15));
        vecs.push_back(mv(0, 25, 0, 0, 0, 11'h010, 16'h0000, 10'h020, 3, 0, 0, 0, 0, 0, 15));
        vecs.push_back(mv(1, 18, 1, 0, 0, 11'h000, 16'h8000, 10'h3FF, 14, 0, F, F, 0, 0, 0));
        vecs.push_back(mv(1, 19, 1, 0, 0, 11'h000, 16'h0001, 10'h000, 15, 0, F, F, 0, 0, 0));
        vecs.push_back(mv(1, 20, 1, 0, 0, 11'h000, 16'h0002, 10'h000, 0, 0, F, F, 0, 0, 0));
        vecs.push_back(mv(1, 23, 1, 0, 0, 11'h000, 16'h0000, 10'h000, 3, 0, F, F, 0, 0, 0));
        vecs.push_back(mv(1, 24, 1, 0, 0, 11'h000, 16'h0000, 10'h000, 3, 0, 0, 0, 0, F, 0));
        vecs.push_back(mv(1, 40, 1, 1, 0, 11'h000, 16'h0000, 10'h000, 3, 0, 0, 0, 0, 0, 15));
        vecs.push_back(mv(1, 41, 0, 0, 0, 11'h000, 16'h0000, 10'h000, 3, 0, 0, 0, 0, 0, 15));
        vecs.push_back(mv(2,  1, 1, 0, F, 11'h005, 16'h0000, 10'h000, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mv(2,  3, 1, 0, 0, 11'h005, 16'h0001, 10'h100, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mv(2,  4, 1, 0, 0, 11'h005, 16'h0000, 10'h100, 0, 0, F, F, 0, 0, 0));
        vecs.push_back(mv(2,  5, 1, 0, 0, 11'h005, 16'h0000, 10'h100, 0, 0, 0, 0, 0, F, 0));
        vecs.push_back(mv(2, 20, 1, 0, 0, 11'h005, 16'h0000, 10'h100, 0, 0, 0, 0, 0, F, 15));
        vecs.push_back(mv(2, 21, 1, 0, F, 11'h006, 16'h0000, 10'h100, 0, 0, 0, 0, 0, 0, 15));
        vecs.push_back(mv(2, 22, 1, 0, 0, 11'h006, 16'h0000, 10'h100, 0, F, 0, 0, F, 0, 15));
        vecs.push_back(mv(2, 41, 1, 0, F, 11'h007, 16'h0000, 10'h100, 0, 0, 0, 0, 0, 0, 15));
        vecs.push_back(mv(2, 60, 1, 0, 0, 11'h007, 16'h0000, 10'h100, 0, 0, 0, 0, 0, F, 15));
        vecs.push_back(mv(2, 61, 1, 1, 0, 11'h007, 16'h0000, 10'h100, 0, 0, 0, 0, 0, 0, 15));
        vecs.push_back(mv(2, 62, 0, 0, 0, 11'h007, 16'h0000, 10'h100, 0, 0, 0, 0, 0, 0, 15));
        vecs.push_back(mv(3,  1, 1, 1, 0, 11'h000, 16'h0000, 10'h000, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mv(3,  2, 0, 0, 0, 11'h000, 16'h0000, 10'h000, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mv(4,  1, 1, 1, 0, 11'h000, 16'h0000, 10'h000, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mv(4,  2, 0, 0, 0, 11'h000, 16'h0000, 10'h000, 0, 0, 0, 0, 0, 0, 0));

        for (int ji = 0; ji < 5; ji++) begin
            run_job(ji);
            foreach (vecs[vi]) begin
                if (vecs[vi].job == ji) check_vec(vecs[vi]);
            end
        end

        // start while busy is ignored: done stays at cycle 24
        begin_job(jobs[0]);
        repeat (10) tick();
        cfg_if_len = 14'd0; cfg_w_base = 11'h7FF; start = 1'b1;
        tick();
        chk("busy_start done c11", 256'(done), 256'(1'b0));
        chk("busy_start busy c11", 256'(busy), 256'(1'b1));
        repeat (13) tick();
        chk("busy_start done c24", 256'(done), 256'(1'b1));
        chk("busy_start w_addr", 256'(w_addr_rd_flat), 256'({NB{11'h010}}));

        // abort at STREAM cycle 2 (cycle 5)
        begin_job('{11'h001, 10'h002, 14'd8, 8'd1, 0});
        repeat (5) tick();
        chk("abort pre if_re", 256'(if_re), 256'(16'h0004));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", 256'(busy), 256'(1'b0));
        chk("abort enables", 256'({w_re, if_re, en_weight_load, en_ifmap_load, en_psum, clear_psum, en_output}), 256'(0));
        saw_done = done;
        repeat (30) begin
            tick();
            saw_done |= done;
        end
        chk("abort no done", 256'(saw_done), 256'(1'b0));
        drive_cfg('{11'h000, 10'h000, 14'd0, 8'd1, 0});
        tick();
        chk("abort restart done", 256'(done), 256'(1'b1));
        tick();

        // asynchronous reset during DRAIN (if_len=2: drain at cycles 6..21)
        begin_job('{11'h012, 10'h034, 14'd2, 8'd1, 0});
        repeat (10) tick();
        chk("rst pre en_out", 256'(en_output), 256'(16'hFFFF));
        rst_n = 1'b0;
        #1;
        chk("rst busy", 256'(busy), 256'(1'b0));
        chk("rst enables", 256'({w_re, if_re, en_weight_load, en_ifmap_load, en_psum, clear_psum, en_output}), 256'(0));
        chk("rst addr", 256'({w_addr_rd_flat, if_addr_rd_flat}), 256'(0));
        chk("rst sel", 256'({ifmap_sel, done_select}), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (30) begin
            tick();
            saw_done |= done | busy;
        end
        chk("rst no done", 256'(saw_done), 256'(1'b0));

`ifdef TCONV_SCHED_PERF_EN
        begin_job(jobs[0]);
        repeat (10) tick();
        chk("perf c10", 256'(perf_cycles), 256'(32'd9));
        repeat (20) tick();
        chk("perf final", 256'(perf_cycles), 256'(32'd24));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
